// File: rtl/inert_sensor_reader.sv
// inert_sensor_reader: SPI master that configures the inertial sensor and reads rate/accel bursts on INT
module inert_sensor_reader #(
    parameter bit FAST_SIM   = 1'b0,
    parameter int SCLK_DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    input  logic        INT,
    output logic        vld,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt,
    output logic [15:0] AY,
    output logic [15:0] AZ
);

    typedef enum logic [3:0] {
        RST_WAIT, CFG0, CFG1, CFG2, CFG3, IDLE,
        RD0, RD1, RD2, RD3, RD4, RD5, RD6, RD7, UPDATE
    } state_t;

    localparam logic [SCLK_DIV_W-1:0] HALF    = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
    localparam logic [SCLK_DIV_W-1:0] RISE_AT = HALF - 1'b1;

    state_t state, nxt;
    logic [15:0] pwr_cnt;
    logic        pwr_done;
    logic [2:0]  int_ff;
    logic [1:0]  miso_ff;
    logic        int_rise;
    logic        start;
    logic [15:0] cmd;
    logic [SCLK_DIV_W-1:0] div;
    logic        busy, fin, done;
    logic [4:0]  rises;
    logic [15:0] tx;
    logic [7:0]  rx;
    logic        rise_now, fall_now;
    logic [7:0]  hold [0:7];

    assign pwr_done = FAST_SIM ? &pwr_cnt[8:0] : &pwr_cnt;
    assign int_rise = int_ff[1] & ~int_ff[2];
    assign rise_now = busy && (div == RISE_AT);
    assign fall_now = busy && (&div);
    assign SCLK     = div[SCLK_DIV_W-1];
    assign MOSI     = tx[15];

    // Synchronise INT (third stage for edge detect) and MISO
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            int_ff  <= '0;
            miso_ff <= '0;
        end else begin
            int_ff  <= {int_ff[1:0], INT};
            miso_ff <= {miso_ff[0], MISO};
        end

    // State register and power-up wait counter
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= RST_WAIT;
            pwr_cnt <= '0;
        end else begin
            state   <= nxt;
            pwr_cnt <= (state == RST_WAIT) ? pwr_cnt + 16'd1 : '0;
        end

    // Sequencing: each transaction state launches its successor's frame on done
    always_comb begin
        nxt   = state;
        start = 1'b0;
        unique case (state)
            RST_WAIT: if (pwr_done) begin nxt = CFG0; start = 1'b1; end
            CFG0, CFG1, CFG2, RD0, RD1, RD2, RD3, RD4, RD5, RD6:
                if (done) begin nxt = state_t'(state + 4'd1); start = 1'b1; end
            CFG3:     if (done) nxt = IDLE;
            IDLE:     if (int_rise) begin nxt = RD0; start = 1'b1; end
            RD7:      if (done) nxt = UPDATE;
            UPDATE:   nxt = IDLE;
            default:  nxt = RST_WAIT;
        endcase
    end

    // Command word for the frame being launched
    always_comb begin
        cmd = 16'hFFFF;
        case (nxt)
            CFG0: cmd = 16'h0D02;
            CFG1: cmd = 16'h1053;
            CFG2: cmd = 16'h1150;
            CFG3: cmd = 16'h1460;
            RD0:  cmd = 16'hA400;
            RD1:  cmd = 16'hA500;
            RD2:  cmd = 16'hA600;
            RD3:  cmd = 16'hA700;
            RD4:  cmd = 16'hAA00;
            RD5:  cmd = 16'hAB00;
            RD6:  cmd = 16'hAC00;
            RD7:  cmd = 16'hAD00;
            default: cmd = 16'hFFFF;
        endcase
    end

    // SPI mode-3 frame engine: SCLK is the div MSB, idling high with div parked at HALF
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy  <= 1'b0;
            SS_n  <= 1'b1;
            div   <= HALF;
            rises <= '0;
            tx    <= '1;
            rx    <= '0;
            fin   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= fin;
            fin  <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                SS_n  <= 1'b0;
                div   <= HALF;
                rises <= '0;
                tx    <= cmd;
            end else if (busy) begin
                if (fall_now && rises == 5'd16) begin
                    busy <= 1'b0;
                    SS_n <= 1'b1;
                    div  <= HALF;
                    tx   <= '1;
                    fin  <= 1'b1;
                end else begin
                    div <= div + 1'b1;
                    if (rise_now) begin
                        rx    <= {rx[6:0], miso_ff[1]};
                        rises <= rises + 5'd1;
                    end
                    if (fall_now && rises != 5'd0) tx <= {tx[14:0], 1'b0};
                end
            end
        end

    // Holding bytes: 0/1 roll L/H, 2/3 yaw L/H, 4/5 AY L/H, 6/7 AZ L/H
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hold[i] <= '0;
        end else if (done && state >= RD0 && state <= RD7) begin
            hold[3'(state - RD0)] <= rx;
        end

    // Publish all words together on the cycle after the last read; AZ_H bypasses its holding byte
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vld     <= 1'b0;
            roll_rt <= '0;
            yaw_rt  <= '0;
            AY      <= '0;
            AZ      <= '0;
        end else begin
            vld <= (state == RD7) && done;
            if (state == RD7 && done) begin
                roll_rt <= {hold[1], hold[0]};
                yaw_rt  <= {hold[3], hold[2]};
                AY      <= {hold[5], hold[4]};
                AZ      <= {rx, hold[6]};
            end
        end

endmodule
